// File: rtl/fifo_write_ctrl_tmr.sv
// Purpose: write-side pointer/full controller for the async FIFO, pointer state triplicated and voted every cycle.
// Latency: write_enable is combinational from registered state; full/almost-full register one cycle after the write.
// Backpressure: write_full blocks write_inc; it clears SYNC_STAGES+1 cycles after the read pointer advances.
module fifo_write_ctrl_tmr #(
  parameter int ADDRESS_SIZE       = 10,
  parameter int ALMOST_FULL_MARGIN = 4,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                    write_clk,
  input  logic                    write_rst_n,
  input  logic                    write_inc,
  input  logic [ADDRESS_SIZE:0]   read_pointer_gray,
  output logic                    write_enable,
  output logic [ADDRESS_SIZE-1:0] write_address,
  output logic                    write_full,
  output logic                    write_almost_full,
  output logic [ADDRESS_SIZE:0]   write_pointer_gray,
  output logic                    seu_detected,
  output logic [7:0]              seu_count
);

  localparam int A = ADDRESS_SIZE;
  localparam logic [A+1:0] DEPTH_W  = (A+2)'(2**A);
  localparam logic [A+1:0] MARGIN_W = (A+2)'(ALMOST_FULL_MARGIN);

  typedef logic [A:0] ptr_t;

  function automatic ptr_t vote3(input ptr_t a, input ptr_t b, input ptr_t c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[A] = g[A];
    for (int i = A - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [1:0] rst_sync;
  logic       rst_n_sync;

  ptr_t wbin0, wbin1, wbin2;
  ptr_t wgray0, wgray1, wgray2;
  ptr_t vbin, vgray;
  ptr_t wbin_next, wgray_next;
  ptr_t sync_q [SYNC_STAGES];
  ptr_t rq_gray, rbin_sync, used;
  logic [A+1:0] free_slots;
  logic full_q, almost_full_q, full_next, almost_full_next;
  logic mismatch;
  logic seu_det_q;
  logic [7:0] seu_cnt_q;

  // Reset asserts immediately, but its release is retimed onto write_clk.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) rst_sync <= 2'b00;
    else              rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_sync = rst_sync[1];

  assign vbin  = vote3(wbin0, wbin1, wbin2);
  assign vgray = vote3(wgray0, wgray1, wgray2);
  assign rq_gray = sync_q[SYNC_STAGES-1];

  // Gated by the internal reset so no strobe escapes while pointers are held clear.
  assign write_enable = write_inc & ~full_q & rst_n_sync;

  // Next pointer, full and almost-full, all derived from the voted value only.
  always_comb begin
    wbin_next        = vbin + {{A{1'b0}}, write_enable};
    wgray_next       = (wbin_next >> 1) ^ wbin_next;
    rbin_sync        = gray2bin(rq_gray);
    used             = wbin_next - rbin_sync;
    free_slots       = DEPTH_W - {1'b0, used};
    full_next        = (wgray_next == {~rq_gray[A:A-1], rq_gray[A-2:0]});
    almost_full_next = (free_slots <= MARGIN_W);
    mismatch         = (wbin0 != vbin) | (wbin1 != vbin) | (wbin2 != vbin) |
                       (wgray0 != vgray) | (wgray1 != vgray) | (wgray2 != vgray);
  end

  // Read pointer crosses into write_clk through a plain flop chain (Gray, so one bit moves at a time).
  always_ff @(posedge write_clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= read_pointer_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // All three copies reload from the vote, which scrubs a single upset in one cycle.
  always_ff @(posedge write_clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      wbin0  <= '0;
      wbin1  <= '0;
      wbin2  <= '0;
      wgray0 <= '0;
      wgray1 <= '0;
      wgray2 <= '0;
    end else begin
      wbin0  <= wbin_next;
      wbin1  <= wbin_next;
      wbin2  <= wbin_next;
      wgray0 <= wgray_next;
      wgray1 <= wgray_next;
      wgray2 <= wgray_next;
    end
  end

  // Registered flags and the saturating upset counter.
  always_ff @(posedge write_clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      seu_det_q     <= 1'b0;
      seu_cnt_q     <= '0;
    end else begin
      full_q        <= full_next;
      almost_full_q <= almost_full_next;
      seu_det_q     <= mismatch;
      if (mismatch && (seu_cnt_q != 8'hFF)) seu_cnt_q <= seu_cnt_q + 8'd1;
    end
  end

  assign write_address      = vbin[A-1:0];
  assign write_pointer_gray = vgray;
  assign write_full         = full_q;
  assign write_almost_full  = almost_full_q;
  assign seu_detected       = seu_det_q;
  assign seu_count          = seu_cnt_q;

endmodule

// File: doc/fifo_write_ctrl_tmr.md
Name: fifo_write_ctrl_tmr

Overview:
- Write-side pointer and full-flag controller for the asynchronous FIFO. Runs entirely in the write_clk domain.
- Sits directly upstream of the triplicated FIFO memory and drives its write_enable, write_address and write_full inputs.
- Write pointer state is held in three redundant copies, majority-voted every cycle and rewritten from the voted value. A single upset is masked and scrubbed within one cycle.
- Also exports the Gray-coded write pointer to the read domain and receives the read Gray pointer, which it synchronises internally.

Parameters:
- ADDRESS_SIZE, 10, memory address width; FIFO depth = 2**ADDRESS_SIZE.
- ALMOST_FULL_MARGIN, 4, write_almost_full asserts when free slots <= this value; legal range 1..2**ADDRESS_SIZE-1.
- SYNC_STAGES, 2, flip-flop stages on the incoming read pointer; minimum 2.

Ports:
- write_clk  input  1  write-domain clock.
- write_rst_n  input  1  asynchronous active-low reset; asserts immediately, internally released on write_clk.
- write_inc  input  1  producer write request for this cycle.
- read_pointer_gray  input  ADDRESS_SIZE+1  Gray read pointer from the read domain; asynchronous to write_clk.
- write_enable  output  1  write strobe to memory = write_inc & ~write_full; combinational from registered state.
- write_address  output  ADDRESS_SIZE  voted binary write pointer, low ADDRESS_SIZE bits.
- write_full  output  1  registered full flag.
- write_almost_full  output  1  registered almost-full flag.
- write_pointer_gray  output  ADDRESS_SIZE+1  voted Gray write pointer, registered, for the read-domain synchroniser.
- seu_detected  output  1  one-cycle pulse when any copy disagrees with the vote.
- seu_count  output  8  saturating count of cycles with a disagreement.

Behaviour:
- Reset (asynchronous, active low):
  - All three binary and Gray pointer copies, and all synchroniser stages, clear to 0.
  - write_full=0, write_almost_full=0, write_pointer_gray=0, write_address=0, seu_detected=0, seu_count=0.
- Triplication:
  - Each copy holds wbin[ADDRESS_SIZE:0] and wgray[ADDRESS_SIZE:0].
  - Voted value is the bitwise majority of the three copies.
  - Each cycle all copies load the same next value, computed from the voted value only.
- Increment and pointer update:
  - wbin_next = vbin + (write_inc & ~write_full), modulo 2**(ADDRESS_SIZE+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - write_enable is high in exactly the cycles where the pointer advances.
  - Data lands at the pre-increment write_address.
- Synchroniser: read_pointer_gray passes through SYNC_STAGES flops to give rq_gray. The read pointer is visible to full logic SYNC_STAGES cycles after it changes.
- Full flag:
  - full_next = (wgray_next == {~rq_gray[A:A-1], rq_gray[A-2:0]}), where A = ADDRESS_SIZE.
  - Registered, so write_full asserts the cycle after the write that fills the last slot.
  - Deasserts SYNC_STAGES+1 cycles after the read pointer moves.
  - A write_inc while write_full=1 is ignored: no pointer change, write_enable=0.
- Almost full:
  - rbin_sync = Gray-to-binary(rq_gray).
  - used = (wbin_next - rbin_sync) mod 2**(A+1).
  - write_almost_full_next = (2**A - used) <= ALMOST_FULL_MARGIN.
  - Registered; always 1 whenever write_full=1.
- Wrap-around: the pointer MSB toggles on each pass through depth. Full versus empty is distinguished by MSB/second-MSB inversion in Gray form. No special case beyond the formula.
- Simultaneous events: a write on the same cycle the synchronised read pointer advances uses the new rq_gray for full_next. Full may therefore stay 0 when one slot was just freed.
- Disagreement detection:
  - Any bit of any copy differing from the vote pulses seu_detected for one cycle.
  - seu_count increments on that cycle and saturates at 255.
  - The pointer outputs are unaffected.
- Double upset in the same bit: the vote follows the majority. Behaviour is undefined by design; the block does not detect this case.
- Reset mid-operation: all state clears immediately regardless of write_inc. The read side must also be reset to keep pointers consistent.

Test Plan:
- ADDRESS_SIZE=4, reset, read pointer held 0, write_inc=1 for 20 cycles:
  - write_address steps 0..15.
  - write_almost_full rises after 12 writes (margin 4).
  - write_full=1 after the 16th write; writes 17..20 give write_enable=0 and the address holds at 0.
- From full, change read_pointer_gray to Gray(3)=5'b00010:
  - write_full drops exactly 3 cycles later (SYNC_STAGES=2).
  - Exactly 3 further writes are accepted, then full again.
- Continuous write and read for 40 writes:
  - wbin wraps through 31→0.
  - write_pointer_gray is a valid Gray sequence, only 1 bit changing per increment.
  - write_full never asserts while the read pointer stays within 8 of the write pointer.
- Force copy 1 wbin to 5'b10101 for one cycle at wbin=3:
  - write_address stays 3 (increments normally).
  - seu_detected pulses once and seu_count=1.
  - Copy 1 matches the vote next cycle.
- Inject 300 single-copy upsets: seu_count saturates at 255 and pointer outputs remain correct throughout.
- Assert write_rst_n low mid-burst at wbin=9, asynchronously between edges:
  - All outputs go to 0 before the next edge.
  - After release, the first write goes to address 0.
